// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: default geometry, stage-count helper and the
// per-stage control payload.
package pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SEG   = 4;

    // Pipeline depth: one stage per SEG-bit segment.
    function automatic int unsigned nstg(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

    // Control part of a stage payload. Partial sum and remaining operand bits have a
    // stage-dependent width, so they live next to this in the stage registers.
    typedef struct packed {
        logic valid;
        logic carry;
    } stg_ctrl_t;

endpackage

// File: rtl/adder_seg.sv
// SEG-bit combinational ripple-carry segment used once per pipeline stage.
module adder_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_c,
    output logic [SEG-1:0] o_s,
    output logic           o_c
);

    // Ripple the carry through SEG full-adder cells.
    always_comb begin
        logic w_c;
        w_c = i_c;
        o_s = '0;
        for (int i = 0; i < int'(SEG); i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_c = w_c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, one SEG-bit ripple segment per stage, valid/ready on both sides.
// Optional subtract mode is enabled by defining PIPE_ADDER_SUB_EN (adds the sub port).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSTG = nstg(WIDTH, SEG);

    if ((WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of SEG");
    end

    logic [NSTG-1:0] w_vld;
    logic [NSTG-1:0] w_adv;
    logic            w_accept;

    // A stage advances when the rest of the pipe ahead of it has a hole or drains at the output.
    always_comb begin
        logic w_room;
        w_room = out_ready;
        w_adv  = '0;
        for (int i = int'(NSTG) - 1; i >= 0; i--) begin
            w_adv[i] = w_vld[i] && w_room;
            w_room   = w_room || !w_vld[i];
        end
    end

    assign in_ready = !w_vld[0] || w_adv[0];
    assign w_accept = in_valid && in_ready;

    for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
        // Operand bits still to be added when entering this stage.
        localparam int unsigned REM  = WIDTH - k * SEG;
        localparam int unsigned DONE = k * SEG;

        logic [REM-1:0]       w_a_in;
        logic [REM-1:0]       w_b_in;
        logic                 w_c_in;
        logic                 w_load;
        logic [SEG-1:0]       w_b_seg;
        logic [SEG-1:0]       w_s;
        logic                 w_co;
        logic [DONE+SEG-1:0]  w_sum_nx;
        stg_ctrl_t            r_ctl;
        logic [DONE+SEG-1:0]  r_sum;
`ifdef PIPE_ADDER_SUB_EN
        logic                 w_sub_in;
`endif

        if (k == 0) begin : g_first
            assign w_a_in   = a;
            assign w_b_in   = b;
            assign w_load   = w_accept;
            assign w_sum_nx = w_s;
`ifdef PIPE_ADDER_SUB_EN
            assign w_sub_in = sub;
            // Borrow-style subtract: a + ~b + !cin.
            assign w_c_in   = cin ^ sub;
`else
            assign w_c_in   = cin;
`endif
        end else begin : g_rest
            assign w_a_in   = g_stg[k-1].g_keep.r_a;
            assign w_b_in   = g_stg[k-1].g_keep.r_b;
            assign w_c_in   = g_stg[k-1].r_ctl.carry;
            assign w_load   = w_adv[k-1];
            assign w_sum_nx = {w_s, g_stg[k-1].r_sum};
`ifdef PIPE_ADDER_SUB_EN
            assign w_sub_in = g_stg[k-1].g_keep.r_sub;
`endif
        end

`ifdef PIPE_ADDER_SUB_EN
        // b travels un-inverted; each stage inverts its own segment from the carried sub flag.
        assign w_b_seg = w_sub_in ? ~w_b_in[SEG-1:0] : w_b_in[SEG-1:0];
`else
        assign w_b_seg = w_b_in[SEG-1:0];
`endif

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .i_a (w_a_in[SEG-1:0]),
            .i_b (w_b_seg),
            .i_c (w_c_in),
            .o_s (w_s),
            .o_c (w_co)
        );

        assign w_vld[k] = r_ctl.valid;

        // Stage valid/carry/partial sum: load on upstream transfer, hold when stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctl <= '0;
                r_sum <= '0;
            end else if (w_load) begin
                r_ctl.valid <= 1'b1;
                r_ctl.carry <= w_co;
                r_sum       <= w_sum_nx;
            end else if (w_adv[k]) begin
                r_ctl.valid <= 1'b0;
            end
        end

        if (k < int'(NSTG) - 1) begin : g_keep
            logic [REM-SEG-1:0] r_a;
            logic [REM-SEG-1:0] r_b;
`ifdef PIPE_ADDER_SUB_EN
            logic               r_sub;
`endif

            // Upper operand bits carried forward for later stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
`ifdef PIPE_ADDER_SUB_EN
                    r_sub <= 1'b0;
`endif
                end else if (w_load) begin
                    r_a <= w_a_in[REM-1:SEG];
                    r_b <= w_b_in[REM-1:SEG];
`ifdef PIPE_ADDER_SUB_EN
                    r_sub <= w_sub_in;
`endif
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].r_ctl.valid;
    assign cout      = g_stg[NSTG-1].r_ctl.carry;
    assign sum       = g_stg[NSTG-1].r_sum;

endmodule
